// File: rtl/axil_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge, one transaction in flight at a time.
// Optional macro AXIL_WB_TIMEOUT_EN ends unanswered Wishbone cycles as errors after TIMEOUT_CYCLES.
module axil_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("axil_wb_bridge: illegal DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {S_IDLE, S_WB_WR, S_WB_RD, S_B_RESP, S_R_RESP} state_t;

    state_t                  r_state;
    logic                    r_last_wr;
    logic                    r_rdy_en;
    logic                    r_aw_full;
    logic                    r_w_full;
    logic                    r_ar_full;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [ADDR_WIDTH-1:0]   r_ar_addr;

    logic w_aw_take;
    logic w_w_take;
    logic w_ar_take;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_tmo;
    logic w_term;
    logic w_err;
    logic w_free_wr;
    logic w_free_rd;

    // Readies stay low through reset and rise on the first edge after release.
    assign s_awready = r_rdy_en & ~r_aw_full;
    assign s_wready  = r_rdy_en & ~r_w_full;
    assign s_arready = r_rdy_en & ~r_ar_full;

    assign w_aw_take = s_awvalid & s_awready;
    assign w_w_take  = s_wvalid & s_wready;
    assign w_ar_take = s_arvalid & s_arready;
    assign w_wr_elig = r_aw_full & r_w_full;
    assign w_rd_elig = r_ar_full;

    // A late ack still beats the timeout in the same cycle; err beats ack.
    assign w_term    = wb_ack_i | wb_err_i | w_tmo;
    assign w_err     = wb_err_i | (w_tmo & ~wb_ack_i);
    assign w_free_wr = (r_state == S_WB_WR) & w_term;
    assign w_free_rd = (r_state == S_WB_RD) & w_term;

`ifdef AXIL_WB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    assign w_tmo = (r_state == S_WB_WR || r_state == S_WB_RD) &&
                   (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_core) begin
        if (rst_core || r_state == S_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WB_WR || r_state == S_WB_RD) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_rdy_en  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_aw_take)      r_aw_full <= 1'b1;
            else if (w_free_wr) r_aw_full <= 1'b0;
            if (w_w_take)       r_w_full  <= 1'b1;
            else if (w_free_wr) r_w_full  <= 1'b0;
            if (w_ar_take)      r_ar_full <= 1'b1;
            else if (w_free_rd) r_ar_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (w_aw_take) r_aw_addr <= s_awaddr;
        if (w_w_take) begin
            r_wdata <= s_wdata;
            r_wstrb <= s_wstrb;
        end
        if (w_ar_take) r_ar_addr <= s_araddr;
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state   <= S_IDLE;
            r_last_wr <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_rvalid  <= 1'b0;
            s_rresp   <= 2'b00;
            s_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
                        r_state   <= S_WB_WR;
                        r_last_wr <= 1'b1;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b1;
                        wb_adr_o  <= r_aw_addr;
                        wb_dat_o  <= r_wdata;
                        wb_sel_o  <= r_wstrb;
                    end else if (w_rd_elig) begin
                        r_state   <= S_WB_RD;
                        r_last_wr <= 1'b0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b0;
                        wb_adr_o  <= r_ar_addr;
                        wb_sel_o  <= {STRB_W{1'b1}};
                    end
                end
                S_WB_WR: begin
                    if (w_term) begin
                        r_state  <= S_B_RESP;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bresp  <= w_err ? 2'b10 : 2'b00;
                    end
                end
                S_WB_RD: begin
                    if (w_term) begin
                        r_state  <= S_R_RESP;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        s_rvalid <= 1'b1;
                        s_rresp  <= w_err ? 2'b10 : 2'b00;
                        s_rdata  <= w_err ? '0 : wb_dat_i;
                    end
                end
                S_B_RESP: begin
                    if (s_bready) begin
                        r_state  <= S_IDLE;
                        s_bvalid <= 1'b0;
                    end
                end
                S_R_RESP: begin
                    if (s_rready) begin
                        r_state  <= S_IDLE;
                        s_rvalid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_wb_bridge.sv
// Scoreboard bench for axil_wb_bridge: a Wishbone slave model checks issued cycles,
// a response monitor checks AXI B/R responses against queued expectations.
module tb_axil_wb_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk_core = 1'b0;
    logic          rst_core = 1'b1;
    logic [AW-1:0] s_awaddr = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [DW-1:0] s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b1;
    logic [AW-1:0] s_araddr = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b1;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    always #5 clk_core = ~clk_core;

    axil_wb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_exp_t;

    typedef struct packed {
        logic        is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_exp_t;

    wb_exp_t  wb_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    // Slave behaviour: 0 ack, 1 err, 2 ack+err together, 3 never answer.
    int          slave_lat   = 0;
    int          slave_mode  = 0;
    bit          slave_fixed = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          cyc_len     = 0;
    int          wb_done_cnt = 0;

    function automatic logic [31:0] rd_pattern(input logic [31:0] a);
        return (a << 4) ^ 32'hC0DE_0000;
    endfunction

    // Wishbone slave model and issued-cycle scoreboard
    initial begin
        int          cnt;
        logic        f_we;
        logic [31:0] f_adr;
        logic [31:0] f_dat;
        logic [3:0]  f_sel;
        wb_exp_t     e;
        cnt = 0;
        f_we = 1'b0; f_adr = '0; f_dat = '0; f_sel = '0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk_core);
            if (wb_cyc_o && wb_stb_o) begin
                cnt++;
                cyc_len = cnt;
                if (cnt == 1) begin
                    f_we = wb_we_o; f_adr = wb_adr_o; f_dat = wb_dat_o; f_sel = wb_sel_o;
                end else begin
                    checks++;
                    if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {f_we, f_adr, f_dat, f_sel}) begin
                        errors++;
                        $display("FAIL wb_stable: got we=%b adr=%h dat=%h sel=%h, required we=%b adr=%h dat=%h sel=%h",
                                 wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, f_we, f_adr, f_dat, f_sel);
                    end
                end
                if (slave_mode != 3 && cnt == slave_lat + 1) begin
                    wb_ack_i = (slave_mode == 0 || slave_mode == 2);
                    wb_err_i = (slave_mode == 1 || slave_mode == 2);
                    wb_dat_i = slave_fixed ? slave_rdata : rd_pattern(wb_adr_o);
                    wb_done_cnt++;
                    checks++;
                    if (wb_q.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected: got cycle we=%b adr=%h, required no cycle", wb_we_o, wb_adr_o);
                    end else begin
                        e = wb_q.pop_front();
                        if (wb_we_o !== e.we || wb_adr_o !== e.adr ||
                            (e.we && (wb_dat_o !== e.dat || wb_sel_o !== e.sel)) ||
                            (!e.we && wb_sel_o !== 4'hF)) begin
                            errors++;
                            $display("FAIL wb_txn: got we=%b adr=%h dat=%h sel=%h, required we=%b adr=%h dat=%h sel=%h",
                                     wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, e.we, e.adr, e.dat,
                                     e.we ? e.sel : 4'hF);
                        end
                    end
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end
            end else begin
                cnt = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
        end
    end

    // AXI response monitor
    initial begin
        rsp_exp_t r;
        forever begin
            @(negedge clk_core);
            #1;
            if (s_bvalid && s_bready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: got bresp=%b, required no response", s_bresp);
                end else begin
                    r = rsp_q.pop_front();
                    if (r.is_rd || s_bresp !== r.resp) begin
                        errors++;
                        $display("FAIL b_resp: got B bresp=%b, required %s resp=%b", s_bresp, r.is_rd ? "R" : "B", r.resp);
                    end
                end
            end
            if (s_rvalid && s_rready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected: got rresp=%b rdata=%h, required no response", s_rresp, s_rdata);
                end else begin
                    r = rsp_q.pop_front();
                    if (!r.is_rd || s_rresp !== r.resp || s_rdata !== r.data) begin
                        errors++;
                        $display("FAIL r_resp: got R rresp=%b rdata=%h, required %s resp=%b data=%h",
                                 s_rresp, s_rdata, r.is_rd ? "R" : "B", r.resp, r.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_aw(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk_core);
        s_awaddr = a; s_awvalid = 1'b1;
        while (!s_awready && n < 300) begin @(negedge clk_core); n++; end
        checks++;
        if (!s_awready) begin errors++; $display("FAIL aw_handshake: awready=%b, required 1 within 300 cycles", s_awready); end
        @(negedge clk_core);
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge clk_core);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        while (!s_wready && n < 300) begin @(negedge clk_core); n++; end
        checks++;
        if (!s_wready) begin errors++; $display("FAIL w_handshake: wready=%b, required 1 within 300 cycles", s_wready); end
        @(negedge clk_core);
        s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk_core);
        s_araddr = a; s_arvalid = 1'b1;
        while (!s_arready && n < 300) begin @(negedge clk_core); n++; end
        checks++;
        if (!s_arready) begin errors++; $display("FAIL ar_handshake: arready=%b, required 1 within 300 cycles", s_arready); end
        @(negedge clk_core);
        s_arvalid = 1'b0;
    endtask

    task automatic drain(input int limit, output bit ok);
        int n;
        n = 0;
        while ((wb_q.size() != 0 || rsp_q.size() != 0) && n < limit) begin
            @(negedge clk_core);
            n++;
        end
        ok = (wb_q.size() == 0 && rsp_q.size() == 0);
        repeat (3) @(negedge clk_core);
    endtask

    task automatic test_reset();
        rst_core = 1'b1;
        repeat (2) @(negedge clk_core);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin
            errors++;
            $display("FAIL reset_wb: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, required all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_axi: got rdy=%b%b%b bvalid=%b bresp=%b rvalid=%b rresp=%b rdata=%h, required all 0",
                     s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata);
        end
        rst_core = 1'b0;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rdy_before_edge: got %b, required 000", {s_awready, s_wready, s_arready});
        end
        @(negedge clk_core);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_rdy_after: got %b, required 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_single_write();
        bit ok;
        int d0;
        slave_lat = 2; slave_mode = 0;
        d0 = wb_done_cnt;
        wb_q.push_back('{we: 1'b1, adr: 32'h100, dat: 32'hDEADBEEF, sel: 4'hF});
        rsp_q.push_back('{is_rd: 1'b0, resp: 2'b00, data: 32'h0});
        send_aw(32'h100);
        repeat (2) @(negedge clk_core);
        checks++;
        if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL wr_aw_only: cyc=%b with only AW held, required 0", wb_cyc_o); end
        send_w(32'hDEADBEEF, 4'hF);
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_drain: pending wb=%0d rsp=%0d, required 0/0", wb_q.size(), rsp_q.size()); wb_q.delete(); rsp_q.delete(); end
        checks++;
        if (wb_done_cnt - d0 != 1) begin errors++; $display("FAIL wr_count: got %0d cycles, required 1", wb_done_cnt - d0); end
        checks++;
        if (cyc_len != 3) begin errors++; $display("FAIL wr_cyc_len: got %0d, required 3", cyc_len); end
    endtask

    task automatic test_single_read();
        bit ok;
        slave_lat = 0; slave_mode = 0; slave_fixed = 1'b1; slave_rdata = 32'h12345678;
        wb_q.push_back('{we: 1'b0, adr: 32'h200, dat: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_rd: 1'b1, resp: 2'b00, data: 32'h12345678});
        send_ar(32'h200);
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd_drain: pending wb=%0d rsp=%0d, required 0/0", wb_q.size(), rsp_q.size()); wb_q.delete(); rsp_q.delete(); end
        checks++;
        if (cyc_len != 1) begin errors++; $display("FAIL rd_cyc_len: got %0d, required 1", cyc_len); end
        slave_fixed = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        slave_lat = 1; slave_mode = 0;
        wb_q.push_back('{we: 1'b1, adr: 32'h1000, dat: 32'hA1A1A1A1, sel: 4'h3});
        wb_q.push_back('{we: 1'b0, adr: 32'h2000, dat: 32'h0, sel: 4'hF});
        wb_q.push_back('{we: 1'b1, adr: 32'h1004, dat: 32'hB2B2B2B2, sel: 4'hC});
        wb_q.push_back('{we: 1'b0, adr: 32'h2004, dat: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_rd: 1'b0, resp: 2'b00, data: 32'h0});
        rsp_q.push_back('{is_rd: 1'b1, resp: 2'b00, data: rd_pattern(32'h2000)});
        rsp_q.push_back('{is_rd: 1'b0, resp: 2'b00, data: 32'h0});
        rsp_q.push_back('{is_rd: 1'b1, resp: 2'b00, data: rd_pattern(32'h2004)});
        fork
            begin send_aw(32'h1000); send_aw(32'h1004); end
            begin send_w(32'hA1A1A1A1, 4'h3); send_w(32'hB2B2B2B2, 4'hC); end
            begin send_ar(32'h2000); send_ar(32'h2004); end
        join
        drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: pending wb=%0d rsp=%0d, required 0/0", wb_q.size(), rsp_q.size()); wb_q.delete(); rsp_q.delete(); end
    endtask

    task automatic test_err_read();
        bit          ok;
        int          n;
        slave_lat = 1; slave_mode = 2;
        s_rready = 1'b0;
        wb_q.push_back('{we: 1'b0, adr: 32'h300, dat: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_rd: 1'b1, resp: 2'b10, data: 32'h0});
        send_ar(32'h300);
        n = 0;
        while (!s_rvalid && n < 50) begin @(negedge clk_core); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_rvalid !== 1'b1 || s_rresp !== 2'b10 || s_rdata !== 32'h0) begin
                errors++;
                $display("FAIL err_hold[%0d]: got rvalid=%b rresp=%b rdata=%h, required 1/10/00000000", i, s_rvalid, s_rresp, s_rdata);
            end
            @(negedge clk_core);
        end
        s_rready = 1'b1;
        drain(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL err_drain: pending wb=%0d rsp=%0d, required 0/0", wb_q.size(), rsp_q.size()); wb_q.delete(); rsp_q.delete(); end
        slave_mode = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        slave_mode = 3;
`ifdef AXIL_WB_TIMEOUT_EN
        rsp_q.push_back('{is_rd: 1'b0, resp: 2'b10, data: 32'h0});
        fork
            send_aw(32'h400);
            send_w(32'h55AA55AA, 4'hF);
        join
        drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_drain: pending rsp=%0d, required 0", rsp_q.size()); rsp_q.delete(); end
        checks++;
        if (cyc_len != TMO) begin errors++; $display("FAIL tmo_cyc_len: got %0d, required %0d", cyc_len, TMO); end
`else
        fork
            send_aw(32'h400);
            send_w(32'h55AA55AA, 4'hF);
        join
        n = 0;
        while (!wb_cyc_o && n < 20) begin @(negedge clk_core); n++; end
        repeat (40) @(negedge clk_core);
        checks++;
        if (wb_cyc_o !== 1'b1 || cyc_len < 40) begin
            errors++;
            $display("FAIL notmo_wait: got cyc=%b len=%0d, required cyc=1 len>=40", wb_cyc_o, cyc_len);
        end
        rst_core = 1'b1;
        @(negedge clk_core);
        rst_core = 1'b0;
        @(negedge clk_core);
        ok = 1'b1;
`endif
        checks++;
        if (wb_cyc_o !== 1'b0 || s_bvalid !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL tmo_end: got cyc=%b bvalid=%b, required 0/0", wb_cyc_o, s_bvalid);
        end
        slave_mode = 0;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int n;
        slave_mode = 3;
        send_ar(32'h500);
        n = 0;
        while (!wb_cyc_o && n < 20) begin @(negedge clk_core); n++; end
        repeat (2) @(negedge clk_core);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: got cyc=%b we=%b, required 1/0", wb_cyc_o, wb_we_o);
        end
        rst_core = 1'b1;
        @(negedge clk_core);
        checks++;
        if ({wb_cyc_o, wb_stb_o, s_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_drop: got cyc=%b stb=%b rvalid=%b, required 000", wb_cyc_o, wb_stb_o, s_rvalid);
        end
        rst_core = 1'b0;
        @(negedge clk_core);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL rst_mid_rdy: got %b, required 111", {s_awready, s_wready, s_arready});
        end
        repeat (5) @(negedge clk_core);
        checks++;
        if (s_rvalid !== 1'b0 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got rvalid=%b cyc=%b, required 0/0", s_rvalid, wb_cyc_o);
        end
        slave_mode = 0; slave_lat = 0;
        wb_q.push_back('{we: 1'b0, adr: 32'h504, dat: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_rd: 1'b1, resp: 2'b00, data: rd_pattern(32'h504)});
        send_ar(32'h504);
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_next: pending wb=%0d rsp=%0d, required 0/0", wb_q.size(), rsp_q.size()); wb_q.delete(); rsp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_err_read();
        test_timeout();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
